// File: rtl/chardisp_axil_pkg.sv
// chardisp_axil_pkg: shared response codes, FSM state types and byte-strobe merge for chardisp_axil_regs
package chardisp_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  // Works at the widest supported width; callers zero-extend inputs and truncate the result.
  function automatic logic [63:0] strb_merge(input logic [63:0] old, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = data[b*8 +: 8];
    return m;
  endfunction
endpackage

// File: rtl/chardisp_axil_regs_if.sv
// chardisp_axil_regs_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels)
// master drives addresses/data/valids and response readies; slave drives readies and responses.
interface chardisp_axil_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/chardisp_axil_regs.sv
// chardisp_axil_regs: AXI4-Lite register bank with read-only hardware-sourced slots and write strobes
// Ports: ACLK clock, ARESETN async active-low reset, axi AXI4-Lite slave bundle,
// reg_q register contents (slice i = register i), hw_in read-only sources, wr_pulse per-register write strobe.
module chardisp_axil_regs
  import chardisp_axil_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 8,
  parameter int                  ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  chardisp_axil_regs_if.slave          axi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int IW = ADDR_W - 2;
  localparam int SW = DATA_W / 8;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic up, aw_got, w_got, commit;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DATA_W-1:0] w_data, w_cur, r_cur, merged;
  logic [SW-1:0] w_strb;
  logic [NUM_REGS-1:0] aw_sel, ar_sel, pulse;
  // up holds the readies low until the first clock after reset release
  assign axi.awready = up && w_state == W_IDLE && !aw_got;
  assign axi.wready  = up && w_state == W_IDLE && !w_got;
  assign axi.arready = up && r_state == R_IDLE;
  assign axi.bvalid  = w_state == W_RESP;
  assign axi.rvalid  = r_state == R_DATA;
  assign ar_idx = axi.araddr[ADDR_W-1:2];
  assign commit = w_state == W_IDLE && aw_got && w_got;
  assign merged = DATA_W'(strb_merge(64'(w_cur), 64'(w_data), 8'(w_strb)));
  always_comb begin
    aw_sel = '0;
    ar_sel = '0;
    pulse  = '0;
    w_cur  = '0;
    r_cur  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_sel[i] = aw_idx == IW'(i);
      ar_sel[i] = ar_idx == IW'(i);
      pulse[i]  = commit && aw_sel[i] && !RO_MASK[i];
      if (aw_sel[i]) w_cur = reg_q[i*DATA_W +: DATA_W];
      if (ar_sel[i]) r_cur = reg_q[i*DATA_W +: DATA_W];
    end
    w_next = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (axi.bready ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE ? (axi.arvalid && axi.arready ? R_DATA : R_IDLE) : (axi.rready ? R_IDLE : R_DATA);
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      up        <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      wr_pulse  <= '0;
      axi.bresp <= RESP_OKAY;
      axi.rdata <= '0;
      axi.rresp <= RESP_OKAY;
    end else begin
      up       <= 1'b1;
      wr_pulse <= pulse;
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1;
        aw_idx <= axi.awaddr[ADDR_W-1:2];
      end
      if (axi.wvalid && axi.wready) begin
        w_got  <= 1'b1;
        w_data <= axi.wdata;
        w_strb <= axi.wstrb;
      end
      if (commit) begin
        aw_got    <= 1'b0;
        w_got     <= 1'b0;
        axi.bresp <= |aw_sel ? RESP_OKAY : RESP_SLVERR;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rdata <= r_cur;
        axi.rresp <= |ar_sel ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i*DATA_W +: DATA_W] = hw_in[i*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] q;
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) q <= '0;
        else if (commit && aw_sel[i]) q <= merged;
      end
      assign reg_q[i*DATA_W +: DATA_W] = q;
    end
  end
endmodule

// File: doc/chardisp_axil_regs.md
CHARDISP_AXIL_REGS -- requirements
Module: chardisp_axil_regs

Interface
REQ-001 Parameter DATA_W, 32; AXI data width and register width; 32 or 64.
REQ-002 Parameter NUM_REGS, 8; register count; range 1..64.
REQ-003 Parameter ADDR_W, 8; AXI address width; 2^(ADDR_W-2) SHALL be >= NUM_REGS.
REQ-004 Parameter RO_MASK, 0; NUM_REGS bits; bit i=1 makes register i read-only, sourced from hw_in.
REQ-005 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 AWADDR in ADDR_W; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1 -- write address channel.
REQ-008 WDATA in DATA_W; WSTRB in DATA_W/8; WVALID in 1; WREADY out 1 -- write data channel.
REQ-009 BRESP out 2; BVALID out 1; BREADY in 1 -- write response channel.
REQ-010 ARADDR in ADDR_W; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1 -- read address channel.
REQ-011 RDATA out DATA_W; RRESP out 2; RVALID out 1; RREADY in 1 -- read data channel.
REQ-012 reg_q  out  NUM_REGS*DATA_W  current register contents, register i at slice i.
REQ-013 hw_in  in  NUM_REGS*DATA_W  read-only sources; slice i used only where RO_MASK[i]=1.
REQ-014 wr_pulse  out  NUM_REGS  one-cycle strobe per register written.

Function
REQ-015 Register index = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored; index >= NUM_REGS is out of range.
REQ-016 Write FSM states: W_IDLE, W_RESP.
REQ-017 In W_IDLE, AW and W SHALL be accepted independently, either order; each captured on its handshake, its READY then low until the next W_IDLE entry.
REQ-018 Commit cycle: first cycle with both AW and W captured; the write is applied there and the FSM enters W_RESP with BVALID=1 on the next edge.
REQ-019 Commit merges WDATA into the RW register byte-wise per WSTRB; WSTRB=0 leaves data unchanged but still pulses wr_pulse.
REQ-020 Write to a RO_MASK register: data ignored, BRESP=OKAY(00), no wr_pulse.
REQ-021 Out-of-range write: nothing written, BRESP=SLVERR(10), no wr_pulse.
REQ-022 wr_pulse[i] SHALL be high exactly the cycle BVALID first rises.
REQ-023 BVALID and BRESP held until BREADY; on handshake return to W_IDLE, AWREADY=WREADY=1 next cycle.
REQ-024 Read FSM states: R_IDLE (ARREADY=1), R_DATA (ARREADY=0).
REQ-025 AR handshake captures data; RVALID=1 next cycle with registered RDATA/RRESP, held stable until RREADY.
REQ-026 RDATA = reg for RW, hw_in slice for RO (sampled at AR handshake), 0 with RRESP=SLVERR when out of range.
REQ-027 AR handshake in the commit cycle to the same register: read returns pre-write value.
REQ-028 Read and write paths independent; one outstanding transaction each; max throughput one write per 3 cycles, one read per 2.

Reset
REQ-029 While ARESETN=0: all RW registers 0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, wr_pulse=0, FSMs idle.
REQ-030 First rising edge with ARESETN=1 sets AWREADY=WREADY=ARREADY=1.
REQ-031 Reset mid-transaction abandons it; no partial write visible after reset.

Structure
REQ-032 Package chardisp_axil_pkg holds RESP_OKAY/RESP_SLVERR constants and the write/read FSM state enums.
REQ-033 Single module; no sub-module; byte-strobe merge as a package function.

Verification
REQ-034 Write 0x1,0x2,0x3,0x4 to 0x0..0xC, read back -> equal data, RRESP=00, BRESP=00 each.
REQ-035 W before AW by 3 cycles, WDATA 0xA5A5A5A5 to 0x4 -> single commit, BVALID once, wr_pulse[1] one cycle.
REQ-036 Reg 2 = 0xFFFFFFFF, write 0x12345678 WSTRB=0101 -> readback 0xFF34FF78.
REQ-037 NUM_REGS=8, write/read 0x20 -> BRESP=10, RRESP=10, RDATA=0, no register change.
REQ-038 RO_MASK=0x01, hw_in[0]=0xCAFE0000, write 0x1 to 0x0 -> BRESP=00, readback 0xCAFE0000.
REQ-039 BREADY held low 10 cycles, then ARESETN pulse -> BVALID=0, all reg_q 0, readies 1 after release.
